// File: rtl/ovl_window_sched_pkg.sv
// Shared types and default widths for the ovl_window checker scheduler.
package ovl_window_sched_pkg;

  localparam int unsigned DEF_N_REQ = 4;
  localparam int unsigned DEF_LEN_W = 8;

  // Window sequencing states seen by the shared checker.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    OPEN  = 2'd2,
    END   = 2'd3
  } win_state_e;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
    return ((id + 32'd1) >= n) ? 32'd0 : (id + 32'd1);
  endfunction

endpackage

// File: rtl/ovl_rr_arb.sv
// Combinational round-robin arbiter: lowest requester at or after the pointer wins.
module ovl_rr_arb
  import ovl_window_sched_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] pointer,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  int                 win_off;
  int                 win_idx;

  // Rotate requests so the pointer position sits at bit 0, then take the lowest set bit.
  always_comb begin
    req_dbl = {req, req};
    req_rot = N_REQ'(req_dbl >> pointer);
    win_off = 0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off = i;
      end
    end
    win_idx = int'(pointer) + win_off;
    if (win_idx >= int'(N_REQ)) begin
      win_idx = win_idx - int'(N_REQ);
    end
    grant    = (|req) ? (N_REQ'(1) << win_idx) : '0;
    grant_id = ID_W'(win_idx);
  end

endmodule

// File: rtl/ovl_window_sched.sv
// Shares one ovl_window checker among N_REQ requesters by bracketing
// round-robin granted windows with start_event / end_event pulses.
module ovl_window_sched
  import ovl_window_sched_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned LEN_W = DEF_LEN_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*LEN_W-1:0]   len,
  input  logic                     abort,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     start_event,
  output logic                     end_event,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  win_state_e       state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_d;
  logic [ID_W-1:0]  id_q;
  logic [N_REQ-1:0] gnt_q;
  logic             start_q;
  logic             end_q;
  logic             busy_q;
  logic             done_q;

  logic [N_REQ-1:0] arb_grant;
  logic [ID_W-1:0]  arb_id;
  logic [LEN_W-1:0] len_arr [N_REQ];

  // Unpack the per-requester length fields.
  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_len
    assign len_arr[g] = len[g*LEN_W +: LEN_W];
  end

  ovl_rr_arb #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req      (req),
    .pointer  (ptr_q),
    .grant    (arb_grant),
    .grant_id (arb_id)
  );

  // Priority moves just past the requester being granted.
  assign ptr_d = ID_W'(rr_next(32'(arb_id), N_REQ));

  // Window FSM, length down-counter, pointer and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      end_q   <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= START;
            cnt_q   <= len_arr[arb_id];
            id_q    <= arb_id;
            gnt_q   <= arb_grant;
            ptr_q   <= ptr_d;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if ((cnt_q == '0) || abort) begin
            state_q <= END;
            end_q   <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            state_q <= OPEN;
          end
        end
        OPEN: begin
          cnt_q <= cnt_q - LEN_W'(1);
          if (abort || (cnt_q == LEN_W'(1))) begin
            state_q <= END;
            end_q   <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        END: begin
          // Always pass through IDLE so end and start pulses never overlap.
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign grant_id    = id_q;
  assign start_event = start_q;
  assign end_event   = end_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ovl_window_sched.sv
// Self-checking bench for ovl_window_sched with a window-level reference model.
module tb_ovl_window_sched;

  localparam int N  = 4;
  localparam int LW = 8;

  logic           clock;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*LW-1:0] len;
  logic           abort;
  logic [N-1:0]   gnt;
  logic [1:0]     grant_id;
  logic           start_event;
  logic           end_event;
  logic           busy;
  logic           done;

  int checks;
  int failures;
  int model_ptr;

  ovl_window_sched #(.N_REQ(N), .LEN_W(LW)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .len         (len),
    .abort       (abort),
    .gnt         (gnt),
    .grant_id    (grant_id),
    .start_event (start_event),
    .end_event   (end_event),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: first requesting index at or after the priority pointer.
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    int c;
    for (int o = 0; o < N; o++) begin
      c = (ptr + o) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while (busy !== 1'b0 && n < 600) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle busy=%b required=0", busy);
    end
  endtask

  task automatic test_reset();
    bit found;
    reset = 1'b1; req = 4'b1111; len = '0; abort = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++;
    if ({grant_id, start_event, end_event, busy, done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outs got id=%0d s=%b e=%b b=%b d=%b exp all 0", grant_id, start_event, end_event, busy, done);
    end
    reset = 1'b0;
    model_ptr = 0;
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clock);
      if (start_event === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL reset_first_start got=none exp=start"); end
    checks++;
    if (gnt !== 4'b0001 || grant_id !== 2'd0) begin
      failures++; $display("FAIL reset_first_grant got gnt=%b id=%0d exp gnt=0001 id=0", gnt, grant_id);
    end
    model_ptr = 1;
    req = '0;
    @(negedge clock);
    checks++;
    if (end_event !== 1'b1 || done !== 1'b1) begin
      failures++; $display("FAIL reset_len0_end got e=%b d=%b exp 1 1", end_event, done);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_gap got busy=%b exp=0", busy); end
  endtask

  task automatic test_single();
    int endpos;
    bit gbad, dn;
    wait_idle();
    len = $urandom;
    len[2*LW +: LW] = 8'd13;
    req = 4'b0100;
    @(negedge clock);
    checks++;
    if (start_event !== 1'b1 || gnt !== 4'b0100 || grant_id !== 2'd2) begin
      failures++; $display("FAIL single_start got s=%b gnt=%b id=%0d exp s=1 gnt=0100 id=2", start_event, gnt, grant_id);
    end
    model_ptr = 3;
    req = '0;
    len = $urandom;
    endpos = -1; gbad = 0; dn = 0;
    for (int j = 0; j < 30 && endpos < 0; j++) begin
      @(negedge clock);
      if (gnt !== 4'b0100 || grant_id !== 2'd2) gbad = 1;
      if (end_event === 1'b1) begin endpos = j + 1; dn = done; end
    end
    checks++;
    if (endpos !== 14) begin failures++; $display("FAIL single_end_pos got=%0d exp=14", endpos); end
    checks++;
    if (gbad || !dn) begin failures++; $display("FAIL single_gnt_done got gbad=%b done=%b exp 0 1", gbad, dn); end
  endtask

  task automatic test_round_robin();
    int st_c[$];
    int st_id[$];
    int e;
    bit overlap;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_ptr = 0;
    len = '0;
    req = 4'b1111;
    overlap = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      if (start_event === 1'b1) begin st_c.push_back(c); st_id.push_back(int'(grant_id)); end
      if (start_event === 1'b1 && end_event === 1'b1) overlap = 1;
    end
    req = '0;
    checks++;
    if (st_c.size() != 6) begin failures++; $display("FAIL rr_count got=%0d exp=6", st_c.size()); end
    for (int i = 0; i < st_c.size() && i < 6; i++) begin
      e = pick(4'b1111, model_ptr);
      model_ptr = (e + 1) % N;
      checks++;
      if (st_id[i] != e || st_c[i] != 3 * i) begin
        failures++; $display("FAIL rr_grant%0d got id=%0d cyc=%0d exp id=%0d cyc=%0d", i, st_id[i], st_c[i], e, 3 * i);
      end
    end
    checks++;
    if (overlap) begin failures++; $display("FAIL rr_overlap got=1 exp=0"); end
    wait_idle();
  endtask

  task automatic test_abort_len0();
    int e, endpos;
    bit dn;
    wait_idle();
    len = '0;
    len[1*LW +: LW] = 8'd5;
    req = 4'b0010;
    e = pick(4'b0010, model_ptr);
    model_ptr = (e + 1) % N;
    @(negedge clock);
    req = '0;
    checks++;
    if (start_event !== 1'b1 || grant_id !== 2'(e)) begin
      failures++; $display("FAIL abort_start got s=%b id=%0d exp s=1 id=%0d", start_event, grant_id, e);
    end
    endpos = -1; dn = 0;
    for (int j = 0; j < 12 && endpos < 0; j++) begin
      abort = (j == 2);
      @(negedge clock);
      if (end_event === 1'b1) begin endpos = j + 1; dn = done; end
    end
    abort = 1'b0;
    checks++;
    if (endpos != 3 || !dn) begin failures++; $display("FAIL abort_end got pos=%0d done=%b exp pos=3 done=1", endpos, dn); end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle got busy=%b exp=0", busy); end
    len = '0;
    req = 4'b0100;
    e = pick(4'b0100, model_ptr);
    model_ptr = (e + 1) % N;
    @(negedge clock);
    req = '0;
    checks++;
    if (start_event !== 1'b1 || end_event !== 1'b0 || grant_id !== 2'(e)) begin
      failures++; $display("FAIL len0_start got s=%b e=%b id=%0d exp s=1 e=0 id=%0d", start_event, end_event, grant_id, e);
    end
    @(negedge clock);
    checks++;
    if (end_event !== 1'b1 || start_event !== 1'b0) begin
      failures++; $display("FAIL len0_end got s=%b e=%b exp s=0 e=1", start_event, end_event);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_end;
    wait_idle();
    len = '0;
    len[0 +: LW] = 8'd10;
    req = 4'b0001;
    @(negedge clock);
    req = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0000 || end_event !== 1'b0) begin
      failures++; $display("FAIL midreset_outs got b=%b gnt=%b e=%b exp 0 0000 0", busy, gnt, end_event);
    end
    @(negedge clock);
    reset = 1'b0;
    model_ptr = 0;
    saw_end = 0;
    for (int j = 0; j < 14; j++) begin
      @(negedge clock);
      if (end_event === 1'b1) saw_end = 1;
    end
    checks++;
    if (saw_end) begin failures++; $display("FAIL midreset_no_end got end=1 exp=0"); end
    len = '0;
    req = 4'b1010;
    @(negedge clock);
    req = '0;
    checks++;
    if (start_event !== 1'b1 || gnt !== 4'b0010 || grant_id !== 2'd1) begin
      failures++; $display("FAIL midreset_grant got s=%b gnt=%b id=%0d exp s=1 gnt=0010 id=1", start_event, gnt, grant_id);
    end
    model_ptr = 2;
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] eg;
    int lens[N];
    int exp_id, exp_end, a, endpos;
    bit do_ab, gbad, dn;
    wait_idle();
    for (int it = 0; it < 40; it++) begin
      r = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        lens[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 60)) : int'($urandom_range(0, 6));
        len[i*LW +: LW] = LW'(lens[i]);
      end
      exp_id = pick(r, model_ptr);
      model_ptr = (exp_id + 1) % N;
      eg = 4'b0001 << exp_id;
      do_ab = 1'($urandom_range(0, 1));
      a = do_ab ? int'($urandom_range(0, lens[exp_id])) : -1;
      exp_end = do_ab ? a + 1 : lens[exp_id] + 1;
      req = r;
      abort = 1'($urandom_range(0, 1));
      @(negedge clock);
      checks++;
      if (start_event !== 1'b1 || gnt !== eg || grant_id !== 2'(exp_id)) begin
        failures++; $display("FAIL rand%0d_start got s=%b gnt=%b id=%0d exp s=1 gnt=%b id=%0d", it, start_event, gnt, grant_id, eg, exp_id);
      end
      len = $urandom;
      endpos = -1; gbad = 0; dn = 0;
      for (int j = 0; j <= lens[exp_id] + 3 && endpos < 0; j++) begin
        abort = do_ab ? (j == a) : 1'b0;
        req = 4'($urandom);
        @(negedge clock);
        if (gnt !== eg || grant_id !== 2'(exp_id) || busy !== 1'b1) gbad = 1;
        if (end_event === 1'b1) begin endpos = j + 1; dn = done; end
      end
      checks++;
      if (endpos != exp_end || !dn) begin
        failures++; $display("FAIL rand%0d_end got pos=%0d done=%b exp pos=%0d done=1", it, endpos, dn, exp_end);
      end
      checks++;
      if (gbad) begin failures++; $display("FAIL rand%0d_hold got gnt/id changed exp gnt=%b id=%0d", it, eg, exp_id); end
      abort = 1'($urandom_range(0, 1));
      req = 4'($urandom);
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || start_event !== 1'b0 || gnt !== 4'b0000) begin
        failures++; $display("FAIL rand%0d_gap got b=%b s=%b gnt=%b exp 0 0 0000", it, busy, start_event, gnt);
      end
    end
    req = '0;
    abort = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_ptr = 0;
    reset = 1'b1;
    req = '0;
    len = '0;
    abort = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_abort_len0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ovl_window_sched.md
# ovl_window_sched

Round-robin scheduler that shares a single `ovl_window` checker among several requesters. It grants one requester at a time and drives the checker's `start_event` and `end_event` to bracket a window of requester-specified length. It sits between the stimulus/sequencer logic and the checker instance in the OVL verification harness. The block only sequences `start_event` and `end_event`; `test_expr` routing stays with the granted requester and the mux it owns.

## Interface
Parameters:
- `N_REQ`, 4 — number of requesters (2..16).
- `LEN_W`, 8 — width of the window-length field.

Ports:
- `clock` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high reset.
- `req` in N_REQ — level request per requester; held until the matching `gnt` bit is seen.
- `len` in N_REQ*LEN_W — packed per-requester open-cycle count; slice i = `len[i*LEN_W +: LEN_W]`.
- `abort` in 1 — terminate the current window early.
- `gnt` out N_REQ — one-hot; high while a window is owned (START..END inclusive).
- `grant_id` out $clog2(N_REQ) — index of the current owner; holds its last value when idle.
- `start_event` out 1 — to checker; one-cycle pulse.
- `end_event` out 1 — to checker; one-cycle pulse.
- `busy` out 1 — high in any state other than IDLE.
- `done` out 1 — one-cycle pulse coincident with `end_event`.

All outputs are registered. All reset to 0, and `grant_id` resets to 0.

## Operation
FSM states: IDLE, START, OPEN, END.
- **IDLE:** if any `req` bit is set, the arbiter picks a winner, latches its `len` into the down-counter `cnt`, and the FSM moves to START. Otherwise it stays in IDLE.
- **START:** `start_event`=1 and `gnt[id]`=1.
  - If the latched len is 0, or `abort` is high, the next state is END.
  - Otherwise the next state is OPEN.
- **OPEN:** `cnt` decrements each cycle.
  - When `cnt`==1, the next state is END.
  - `abort` forces END on the next cycle regardless of `cnt`.
- **END:** `end_event`=1 and `done`=1. The next state is always IDLE.
  - This guarantees one idle gap before the next grant, so `end_event` and `start_event` never overlap.
- **Arbitration:** round-robin. The priority pointer is (last granted + 1) mod N_REQ and updates on entry to START. The reset pointer is 0.
- **Request rules:**
  - `req` changes outside IDLE are ignored.
  - `len` is sampled only on the IDLE→START edge.
  - `abort` is ignored in IDLE and END.
- **Reset asserted mid-window:** the FSM returns to IDLE immediately, all outputs go to 0, and no `end_event` is emitted.

## Timing
- `req` seen at edge k → START at k+1 (`start_event`) → END at k+2+L (`end_event`) for latched length L.
- Window length: `start_event` and `end_event` are separated by L+1 cycles. L=0 gives back-to-back pulses.
- Minimum request-to-request service period is L+3 cycles.
- `abort` sampled in OPEN or START at edge m → `end_event` at m+1.
- Maximum L = 2^LEN_W − 1. The counter cannot wrap because it only decrements from the loaded value.

## Structure
- Package `ovl_window_sched_pkg`:
  - state enum `win_state_e` {IDLE, START, OPEN, END};
  - `localparam` default widths.
- Sub-module `ovl_rr_arb` (parameter `N_REQ`):
  - inputs: `req`, `pointer`;
  - outputs: one-hot `grant` and `grant_id`;
  - purely combinational.
- Top level holds the FSM, down-counter, pointer register and output registers.

## Test plan
- **Reset:** hold `reset`=1 with `req`=4'b1111 → all outputs 0. Release `reset` → `gnt`=4'b0001 and `start_event` two edges later.
- **Single requester:** `req`[2]=1 with len[2]=13 → `start_event` at k+1 and `end_event` at k+15; `gnt`=4'b0100 throughout; `grant_id`=2.
- **Round-robin:** `req`=4'b1111 held, all len=0 → grants in order 0,1,2,3,0, with one idle cycle between each END and the next START.
- **Abort and len=0:**
  - len=5 with `abort` pulsed on the second OPEN cycle → `end_event` on the next cycle, `done`=1, return to IDLE.
  - len=0 → `start_event` and `end_event` on consecutive cycles.
- **Reset mid-window:** assert `reset` during OPEN with len=10 → `end_event` never fires and `busy`=0 immediately. After release the pointer is 0, so `req`=4'b1010 grants requester 1.
